rvfi_trace_serializer: RTL and testbench
========================================

// Module: rvfi_trace_serializer
// PURPOSE
//  Core-side producer for the lock-step reference-model flow. Captures per-port RVFI retirement
//  records from the core commit stage and buffers them in order. Emits each record as a sequence
//  of 64-bit words, which is the word-array form the ISS step consumes. Sits between the core
//  RVFI ports and the testbench/DPI bridge that drives the reference-model compare.
// PARAMETERS
//  NRET    2    number of commit ports sampled per cycle
//  REC_W   512  width of one packed RVFI record, in bits
//  DEPTH   8    record FIFO depth, in records (power of 2, >= NRET)
//  NWORDS  (REC_W+63)/64  derived localparam: words per record
// PORTS
//  clk_i           in   1            clock
//  rst_ni          in   1            synchronous reset, active-low
//  flush_i         in   1            synchronous clear of the FIFO and of any in-flight record
//  rec_valid_i     in   NRET         per-port retirement valid
//  rec_i           in   NRET*REC_W   packed records; port p at [p*REC_W +: REC_W]
//  word_valid_o    out  1            word_data_o holds a valid word
//  word_ready_i    in   1            sink accepts the word
//  word_data_o     out  64           current word
//  word_idx_o      out  $clog2(NWORDS) index of the word within its record
//  word_last_o     out  1            current word is word NWORDS-1
//  overflow_o      out  1            sticky: one or more records were dropped
//  drop_cnt_o      out  16           number of dropped records, saturating at 16'hFFFF
//  level_o         out  $clog2(DEPTH)+1 FIFO occupancy, in records
// BEHAVIOUR
//  - Reset (rst_ni=0 at a clk_i edge): FIFO empty, FSM IDLE, all outputs 0.
//  - Enqueue: all valid ports in a cycle are written in ascending port index (port 0 first).
//    Ports need not be contiguous: valid=2'b10 enqueues port 1 only.
//  - Free space per cycle = DEPTH - level + pop, where pop = handshake on the last word this
//    cycle. A full FIFO can accept a new record in the same cycle it pops one.
//  - Insufficient space: the lowest-index valid ports that fit are written and the rest are
//    dropped. Each dropped record increments drop_cnt_o and sets overflow_o. overflow_o clears
//    only on reset, not on flush.
//  - FSM IDLE: when level>0, the FIFO head is loaded into the shift register, idx is set to 0,
//    and the FSM moves to SEND. Record written at edge N -> word_valid_o=1 in cycle N+2.
//  - FSM SEND: word_valid_o=1 and word_data_o = rec[idx*64 +: 64]. Word 0 carries bits 63:0.
//  - Handshake = word_valid_o & word_ready_i. It advances idx. data/idx must stay stable while
//    valid=1 and ready=0.
//  - Handshake with word_last_o: the head is popped. If more records remain, the next record is
//    loaded with no bubble (stay in SEND, idx=0). Otherwise the FSM returns to IDLE.
//  - Partial last word: if REC_W is not a multiple of 64, the unused upper bits of the last word
//    are zero.
//  - NWORDS==1: word_last_o is always 1 in SEND. word_idx_o is 1 bit wide and tied to 0.
//  - flush_i: takes priority over enqueue in the same cycle. It empties the FIFO, drops the
//    in-flight record, goes to IDLE, and sets word_valid_o=0 next cycle. drop_cnt_o is unchanged.
//  - Reset mid-record: all state is abandoned and the partial record is never completed.
//  - Pointers wrap modulo DEPTH. level_o reaches DEPTH exactly when the FIFO is full.
// TESTING
//  1. Single record, port0 = pattern of word k = 64'h1111_0000_0000_0000*k+k, ready=1 ->
//     8 words with idx 0..7, last on idx 7, first valid 2 cycles after the write.
//  2. Both ports valid in one cycle with distinct tags (0xA, 0xB), ready=1 ->
//     all of A's words, then all of B's words, with no idle cycle between them.
//  3. ready toggled 1,0,0,1 every cycle -> words are never skipped or duplicated, and
//     data/idx are stable during every stall.
//  4. ready=0, 9 single-port retirements at DEPTH=8 -> level_o=8, overflow_o=1, drop_cnt_o=1;
//     then ready=1 -> the 8 oldest records stream out in order.
//  5. Full FIFO; port0 valid in the same cycle as the last-word handshake -> record accepted,
//     drop_cnt_o unchanged, level_o stays 8.
//  6. flush_i asserted at word idx 3 together with a port0 valid ->
//     word_valid_o=0 next cycle, level_o=0, and no record from that cycle is emitted.

Source files
------------

// File: rtl/rvfi_trace_serializer.sv
// rvfi_trace_serializer: buffers per-port RVFI records in a FIFO and streams each one as 64-bit words
module rvfi_trace_serializer #(
  parameter int NRET = 2,
  parameter int REC_W = 512,
  parameter int DEPTH = 8,
  localparam int NWORDS = (REC_W + 63) / 64,
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NRET-1:0]         rec_valid_i,
  input  logic [NRET*REC_W-1:0]   rec_i,
  output logic                    word_valid_o,
  input  logic                    word_ready_i,
  output logic [63:0]             word_data_o,
  output logic [IW-1:0]           word_idx_o,
  output logic                    word_last_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o,
  output logic [LW-1:0]           level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(NRET + 1);
  localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;
  logic [0:0] state_q, state_d;
  logic [NWORDS*64-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d, free, n_acc;
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;
  logic ovf_q, ovf_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [NRET-1:0] acc;
  logic [PW-1:0] off [NRET];
  logic [DW-1:0] n_drop;
  logic hs, last, pop;

  assign word_valid_o = state_q == SEND;
  assign word_data_o = sr_q[63:0];
  assign word_idx_o = idx_q;
  assign word_last_o = word_valid_o & last;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;
  assign level_o = level_q;
  assign hs = word_valid_o & word_ready_i;
  assign last = idx_q == IW'(NWORDS - 1);
  assign pop = hs & last;
  assign free = LW'(DEPTH) - level_q + LW'(pop);

  // lowest-index valid ports claim the free slots in order; the rest are dropped
  always_comb begin
    n_acc = '0;
    n_drop = '0;
    acc = '0;
    for (int p = 0; p < NRET; p++) begin
      off[p] = n_acc[PW-1:0];
      if (rec_valid_i[p] && !flush_i) begin
        if (n_acc < free) begin
          acc[p] = 1'b1;
          n_acc = n_acc + LW'(1);
        end else n_drop = n_drop + DW'(1);
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d = ovf_q | (n_drop != '0);
    wr_d = flush_i ? '0 : wr_q + n_acc[PW-1:0];
    rd_d = flush_i ? '0 : rd_q + PW'(pop);
    level_d = flush_i ? '0 : level_q - LW'(pop) + n_acc;
    state_d = state_q;
    sr_d = sr_q;
    idx_d = idx_q;
    if (flush_i) begin
      state_d = IDLE;
      idx_d = '0;
    end else if (state_q == IDLE) begin
      if (level_q != '0) begin
        state_d = SEND;
        idx_d = '0;
        sr_d = '0;
        sr_d[REC_W-1:0] = mem_q[rd_q];
      end
    end else if (hs) begin
      if (!last) begin
        sr_d = sr_q >> 64;
        idx_d = idx_q + IW'(1);
      end else if (level_q > LW'(1)) begin
        // back-to-back reload of the next record avoids an idle cycle
        idx_d = '0;
        sr_d = '0;
        sr_d[REC_W-1:0] = mem_q[rd_q + PW'(1)];
      end else begin
        state_d = IDLE;
        idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q <= '0;
      idx_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NRET; p++)
      if (acc[p]) mem_q[wr_q + off[p]] <= rec_i[p*REC_W +: REC_W];
  end
endmodule

// File: tb/tb_rvfi_trace_serializer.sv
// tb_rvfi_trace_serializer: directed and random stimulus checked against a queue-based record model
module tb_rvfi_trace_serializer;
  localparam int NRET = 2, REC_W = 512, DEPTH = 8, NW = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush, rdy;
  logic [NRET-1:0] vld;
  logic [NRET*REC_W-1:0] rec_in;
  logic wv, wl, ovf;
  logic [63:0] wd;
  logic [2:0] wi;
  logic [15:0] dc;
  logic [3:0] lvl;
  logic [REC_W-1:0] mq[$];
  bit m_act, m_ovf;
  int m_idx, m_drop, n_cmp, n_bad;

  rvfi_trace_serializer #(.NRET(NRET), .REC_W(REC_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rec_valid_i(vld), .rec_i(rec_in),
    .word_valid_o(wv), .word_ready_i(rdy), .word_data_o(wd), .word_idx_o(wi),
    .word_last_o(wl), .overflow_o(ovf), .drop_cnt_o(dc), .level_o(lvl)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [REC_W-1:0] r;
    chk("valid", 64'(wv), 64'(m_act));
    if (m_act) begin
      r = mq[0];
      chk("data", wd, r[m_idx*64 +: 64]);
      chk("idx", 64'(wi), 64'(m_idx));
      chk("last", 64'(wl), 64'(m_idx == NW - 1));
    end
    chk("level", 64'(lvl), 64'(mq.size()));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("drop_cnt", 64'(dc), 64'(m_drop));
  endtask

  // record-level view: queue head is the record on the wire, m_idx the word being offered
  task automatic model_update();
    int sz, space;
    bit hs, pop;
    if (!rst_n) begin
      mq.delete(); m_act = 0; m_idx = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    if (flush) begin
      mq.delete(); m_act = 0; m_idx = 0;
      return;
    end
    sz = mq.size();
    hs = m_act && rdy;
    pop = hs && m_idx == NW - 1;
    if (!m_act) begin
      m_act = sz > 0; m_idx = 0;
    end else if (pop) begin
      m_act = sz > 1; m_idx = 0;
    end else if (hs) m_idx++;
    if (pop) void'(mq.pop_front());
    space = DEPTH - mq.size();
    for (int p = 0; p < NRET; p++)
      if (vld[p]) begin
        if (space > 0) begin
          mq.push_back(rec_in[p*REC_W +: REC_W]);
          space--;
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_recs();
    for (int p = 0; p < NRET; p++)
      for (int k = 0; k < NW; k++) rec_in[p*REC_W + k*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic tag_rec(input int p, input logic [31:0] tag);
    for (int k = 0; k < NW; k++) rec_in[p*REC_W + k*64 +: 64] = {tag, 32'(k)};
  endtask

  task automatic drain(input int n);
    vld = '0; flush = 0; rdy = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int saved;
    rst_n = 0; flush = 0; rdy = 1; vld = '1; rec_in = '0;
    rand_recs();
    for (int i = 0; i < 3; i++) step();
    chk("rst_data", wd, 64'h0);
    chk("rst_valid", 64'(wv), 64'h0);
    rst_n = 1; vld = '0;
    step();
    // single record with arithmetic word pattern; valid two edges after the write
    for (int k = 0; k < NW; k++) rec_in[k*64 +: 64] = 64'h1111_0000_0000_0000 * 64'(k) + 64'(k);
    vld = 2'b01;
    step();
    vld = '0;
    chk("t1_lat_idle", 64'(wv), 64'h0);
    step();
    chk("t1_first_valid", 64'(wv), 64'h1);
    chk("t1_word0", wd, 64'h0);
    step();
    chk("t1_word1", wd, 64'h1111_0000_0000_0001);
    drain(12);
    // both ports in one cycle, A before B with no gap
    tag_rec(0, 32'hA); tag_rec(1, 32'hB); vld = 2'b11;
    step();
    drain(24);
    // non-contiguous valid
    tag_rec(1, 32'hC); vld = 2'b10;
    step();
    drain(14);
    // ready pattern 1,0,0,1 across three records
    rand_recs(); vld = 2'b11;
    step();
    rand_recs(); vld = 2'b01;
    step();
    vld = '0;
    for (int i = 0; i < 80; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    drain(20);
    // nine retirements into an eight-deep FIFO while stalled
    rdy = 0;
    for (int i = 0; i < 9; i++) begin
      tag_rec(0, 32'h100 + 32'(i)); vld = 2'b01;
      step();
    end
    vld = '0;
    step();
    chk("t4_level", 64'(lvl), 64'd8);
    chk("t4_overflow", 64'(ovf), 64'h1);
    chk("t4_drop", 64'(dc), 64'h1);
    drain(80);
    // full FIFO accepts a record in the cycle it pops the head
    rdy = 0;
    for (int i = 0; i < 8; i++) begin
      tag_rec(0, 32'h200 + 32'(i)); vld = 2'b01;
      step();
    end
    vld = '0;
    step(); step();
    saved = m_drop;
    rdy = 1;
    for (int i = 0; i < 12; i++) begin
      tag_rec(0, 32'h300);
      vld = (m_act && m_idx == NW - 1) ? 2'b01 : 2'b00;
      step();
    end
    vld = '0; rdy = 0;
    step();
    chk("t5_level", 64'(lvl), 64'd8);
    chk("t5_drop", 64'(dc), 64'(saved));
    drain(80);
    // flush at word 3 alongside a new retirement
    tag_rec(0, 32'h400); vld = 2'b01;
    step();
    vld = '0;
    for (int i = 0; i < 10 && !(m_act && m_idx == 3); i++) step();
    chk("t6_at_idx3", 64'(wi), 64'd3);
    tag_rec(0, 32'h401); vld = 2'b01; flush = 1;
    step();
    vld = '0; flush = 0;
    chk("t6_valid", 64'(wv), 64'h0);
    chk("t6_level", 64'(lvl), 64'h0);
    drain(10);
    // random phases with rising ready probability
    for (int ph = 0; ph < 4; ph++)
      for (int i = 0; i < 600; i++) begin
        rst_n = $urandom_range(0, 499) != 0;
        flush = $urandom_range(0, 63) == 0;
        vld = NRET'($urandom);
        rdy = $urandom_range(0, 2) < ph;
        rand_recs();
        step();
      end
    rst_n = 1;
    drain(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
